action_extr_seq: RTL and testbench
==================================

Name: action_extr_seq

Overview:
Sequencer that drives the action-extraction datapath one rule at a time. It accepts a parsed packet header plus a rule list (base address, count) and reads each 80-bit action entry from a synchronous action RAM. It presents each header/offset/entry triple to the combinational extractor and holds it until downstream consumes the extracted fields. It sits between the parser front-end and the action execution stage.

Parameters:
ADDR_W, 8, action RAM address width
CNT_W, 3, width of rule_cnt (max rules per packet = 2^CNT_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of current packet
hdr_valid  in  1  header/rule-list valid
hdr_ready  out  1  header accepted when valid&ready
hdr_data  in  2048  packet header
hdr_offset  in  12  base bit offset into header
rule_base  in  ADDR_W  first action RAM address
rule_cnt  in  CNT_W  number of action entries for this packet
ram_rd_en  out  1  action RAM read strobe
ram_addr  out  ADDR_W  action RAM address
ram_rdata  in  80  RAM data, valid one cycle after ram_rd_en
ext_header  out  2048  registered header to extractor
ext_offset  out  12  registered offset to extractor
ext_ram  out  80  registered action entry to extractor
act_valid  out  1  extractor outputs valid for current entry
act_ready  in  1  downstream consumed current entry
act_idx  out  CNT_W  index of current entry within packet
act_last  out  1  current entry is final one of packet
pkt_done  out  1  one-cycle pulse when packet finished
pkt_cnt  out  32  packets completed, wraps
act_cnt  out  32  entries handed off, wraps

Behaviour:
- Reset: state IDLE; hdr_ready=1 (combinational from state); all other outputs 0, including ext_* registers, counters, idx.
- States: IDLE, RD, LOAD, OUT.
- IDLE: hdr_ready=1. On hdr_valid: latch hdr_data, hdr_offset, rule_base, rule_cnt, and clear idx.
  - If rule_cnt==0: pulse pkt_done next cycle, increment pkt_cnt, stay IDLE.
  - Else go to RD.
- RD: ram_rd_en=1, ram_addr=rule_base+idx (mod 2^ADDR_W, wraps). Go to LOAD.
- LOAD: register ram_rdata into ext_ram. Go to OUT.
- OUT: act_valid=1. act_last=(idx==rule_cnt-1). ext_* and act_idx stable until handshake.
  - On act_valid&act_ready: increment act_cnt.
  - If last: pulse pkt_done, increment pkt_cnt, go to IDLE.
  - Else: idx+1, go to RD.
- Latency: header accepted at edge T. ram_rd_en high in cycle T+1. act_valid high from cycle T+3. Each further entry adds 3 cycles when act_ready is held high. Packet throughput is 3*N+1 cycles.
- No new header is accepted while busy (hdr_ready=0 outside IDLE). No overlap between packets.
- flush (any state except IDLE): next state IDLE, act_valid drops next cycle, no pkt_done, counters unchanged. flush has priority over a simultaneous act handshake; that entry is not counted. flush in IDLE has no effect; a simultaneous hdr_valid is still accepted.
- A RAM read issued in RD is discarded if flush occurs in the LOAD cycle.
- Asynchronous reset mid-packet: immediate return to reset values; the in-flight packet is lost.
- Counters wrap 0xFFFFFFFF->0 silently.
- ext_header/ext_offset change only on header accept; they are held in IDLE after completion.

Test Plan:
- Single rule: rule_base=0x10, rule_cnt=1, act_ready=1 -> ram_rd_en with addr 0x10 at T+1; act_valid, act_last=1, act_idx=0 at T+3; pkt_done at T+4; pkt_cnt=1, act_cnt=1.
- Three rules with backpressure (act_ready low 5 cycles per entry) -> addresses 0x10/0x11/0x12 in order; ext_ram stable while stalled; act_idx 0,1,2; act_last only on idx 2; act_cnt=3.
- Address wrap: rule_base=0xFE, rule_cnt=3 -> ram_addr sequence 0xFE, 0xFF, 0x00.
- rule_cnt=0 -> no ram_rd_en; pkt_done one cycle after accept; pkt_cnt+1; act_cnt unchanged.
- flush asserted in OUT together with act_ready, rule_cnt=4 at idx 1 -> IDLE next cycle; no pkt_done; act_cnt=1; next header is accepted normally.
- rst_n pulled low in LOAD -> all outputs 0 and hdr_ready=1 immediately; counters 0; after release, a new packet completes with correct latency.

Source files
------------

// File: rtl/action_extr_seq.sv
// Action-extraction sequencer: walks a packet's rule list, fetches each action entry
// from the synchronous action RAM and presents it to the extractor until consumed.
module action_extr_seq #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                hdr_valid,
  output logic                hdr_ready,
  input  logic [2047:0]       hdr_data,
  input  logic [11:0]         hdr_offset,
  input  logic [ADDR_W-1:0]   rule_base,
  input  logic [CNT_W-1:0]    rule_cnt,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [79:0]         ram_rdata,
  output logic [2047:0]       ext_header,
  output logic [11:0]         ext_offset,
  output logic [79:0]         ext_ram,
  output logic                act_valid,
  input  logic                act_ready,
  output logic [CNT_W-1:0]    act_idx,
  output logic                act_last,
  output logic                pkt_done,
  output logic [31:0]         pkt_cnt,
  output logic [31:0]         act_cnt
);

  // state  | meaning
  // S_IDLE | waiting for a header/rule list, hdr_ready high
  // S_RD   | action RAM read strobe for entry r_idx
  // S_LOAD | RAM data returning, captured into ext_ram at end of cycle
  // S_OUT  | entry presented to extractor, waiting for act_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_LOAD = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [2047:0]      r_header;
  logic [11:0]        r_offset;
  logic [ADDR_W-1:0]  r_base;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_idx;
  logic [79:0]        r_ext_ram;
  logic               r_pkt_done;
  logic [31:0]        r_pkt_cnt;
  logic [31:0]        r_act_cnt;

  logic               w_accept;
  logic               w_last;
  logic               w_hs;
  logic               w_zero_pkt;
  logic               w_pkt_end;

  assign w_accept   = (r_state == S_IDLE) && hdr_valid;
  assign w_zero_pkt = w_accept && (rule_cnt == '0);
  assign w_last     = (r_idx == (r_cnt - CNT_W'(1)));
  // flush wins over a simultaneous handshake; that entry is not handed off
  assign w_hs       = (r_state == S_OUT) && act_ready && !flush;
  assign w_pkt_end  = w_zero_pkt || (w_hs && w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (hdr_valid && (rule_cnt != '0)) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_state_nxt = flush ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = flush ? S_IDLE : S_OUT;
      end
      S_OUT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (act_ready) begin
          w_state_nxt = w_last ? S_IDLE : S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = 1'b0;
    ram_rd_en = 1'b0;
    ram_addr  = '0;
    act_valid = 1'b0;
    act_last  = 1'b0;
    case (r_state)
      S_IDLE: hdr_ready = 1'b1;
      S_RD: begin
        ram_rd_en = 1'b1;
        ram_addr  = r_base + ADDR_W'(r_idx);
      end
      S_OUT: begin
        act_valid = 1'b1;
        act_last  = w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_header   <= '0;
      r_offset   <= '0;
      r_base     <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ext_ram  <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_cnt  <= '0;
      r_act_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_header <= hdr_data;
        r_offset <= hdr_offset;
        r_base   <= rule_base;
        r_cnt    <= rule_cnt;
        r_idx    <= '0;
      end else if (w_hs && !w_last) begin
        r_idx <= r_idx + CNT_W'(1);
      end
      // a read in flight is dropped when the packet is aborted during LOAD
      if ((r_state == S_LOAD) && !flush) begin
        r_ext_ram <= ram_rdata;
      end
      r_pkt_done <= w_pkt_end;
      if (w_pkt_end) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (w_hs) begin
        r_act_cnt <= r_act_cnt + 32'd1;
      end
    end
  end

  assign ext_header = r_header;
  assign ext_offset = r_offset;
  assign ext_ram    = r_ext_ram;
  assign act_idx    = r_idx;
  assign pkt_done   = r_pkt_done;
  assign pkt_cnt    = r_pkt_cnt;
  assign act_cnt    = r_act_cnt;

endmodule

// File: tb/tb_action_extr_seq.sv
// Bench for action_extr_seq: behavioural RAM and packet model, randomized packets,
// directed latency, backpressure, wrap, zero-rule, flush and reset scenarios.
module tb_action_extr_seq;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          hdr_valid;
  logic          hdr_ready;
  logic [2047:0] hdr_data;
  logic [11:0]   hdr_offset;
  logic [7:0]    rule_base;
  logic [2:0]    rule_cnt;
  logic          ram_rd_en;
  logic [7:0]    ram_addr;
  logic [79:0]   ram_rdata;
  logic [2047:0] ext_header;
  logic [11:0]   ext_offset;
  logic [79:0]   ext_ram;
  logic          act_valid;
  logic          act_ready;
  logic [2:0]    act_idx;
  logic          act_last;
  logic          pkt_done;
  logic [31:0]   pkt_cnt;
  logic [31:0]   act_cnt;

  logic [79:0]   mem [256];
  int            n_cmp;
  int            n_err;
  logic [31:0]   exp_pkt;
  logic [31:0]   exp_act;
  logic [2047:0] exp_hdr;
  logic [11:0]   exp_off;
  logic [79:0]   exp_ext;

  action_extr_seq #(.ADDR_W(8), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .hdr_data   (hdr_data),
    .hdr_offset (hdr_offset),
    .rule_base  (rule_base),
    .rule_cnt   (rule_cnt),
    .ram_rd_en  (ram_rd_en),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .ext_header (ext_header),
    .ext_offset (ext_offset),
    .ext_ram    (ext_ram),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .act_idx    (act_idx),
    .act_last   (act_last),
    .pkt_done   (pkt_done),
    .pkt_cnt    (pkt_cnt),
    .act_cnt    (act_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous action RAM: data one cycle after the read strobe
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  function automatic logic [2047:0] rand_hdr();
    logic [2047:0] h;
    for (int k = 0; k < 64; k++) h[k*32 +: 32] = $urandom;
    return h;
  endfunction

  // Present one header, then follow the packet entry by entry. Caller must be
  // 1 time unit after a rising edge with the DUT idle.
  task automatic run_pkt(input logic [7:0] base, input logic [2:0] cnt,
                         input int stall_min, input int stall_max);
    logic [7:0] a;
    int ns;
    exp_hdr = rand_hdr();
    exp_off = 12'($urandom);
    n_cmp++;
    if (hdr_ready !== 1'b1) begin
      n_err++; $display("FAIL accept_ready act=%0b exp=1", hdr_ready);
    end
    hdr_valid = 1'b1; hdr_data = exp_hdr; hdr_offset = exp_off;
    rule_base = base; rule_cnt = cnt;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    n_cmp++;
    if (ext_header !== exp_hdr || ext_offset !== exp_off) begin
      n_err++; $display("FAIL hdr_latch act_off=%0h exp_off=%0h act_lo=%0h exp_lo=%0h",
                        ext_offset, exp_off, ext_header[31:0], exp_hdr[31:0]);
    end
    if (cnt == 3'd0) begin
      exp_pkt++;
      n_cmp++;
      if ({pkt_done, ram_rd_en, hdr_ready, act_valid} !== 4'b1010 ||
          pkt_cnt !== exp_pkt || act_cnt !== exp_act) begin
        n_err++; $display("FAIL zero_rule done/rd/rdy/vld=%b exp=1010 pkt=%0d/%0d act=%0d/%0d",
                          {pkt_done, ram_rd_en, hdr_ready, act_valid}, pkt_cnt, exp_pkt, act_cnt, exp_act);
      end
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 8'(i);
      n_cmp++;
      if ({ram_rd_en, act_valid, hdr_ready, pkt_done} !== 4'b1000 || ram_addr !== a) begin
        n_err++; $display("FAIL rd_cycle idx=%0d rd/vld/rdy/done=%b exp=1000 addr=%0h exp=%0h",
                          i, {ram_rd_en, act_valid, hdr_ready, pkt_done}, ram_addr, a);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({ram_rd_en, act_valid, hdr_ready} !== 3'b000) begin
        n_err++; $display("FAIL load_cycle idx=%0d rd/vld/rdy=%b exp=000", i, {ram_rd_en, act_valid, hdr_ready});
      end
      @(posedge clk); #1;
      exp_ext = mem[a];
      n_cmp++;
      if (act_valid !== 1'b1 || act_idx !== 3'(i) || act_last !== (i == int'(cnt) - 1) ||
          ext_ram !== exp_ext) begin
        n_err++; $display("FAIL out_cycle idx=%0d vld=%0b idx_act=%0d last=%0b ram=%0h exp_ram=%0h",
                          i, act_valid, act_idx, act_last, ext_ram, exp_ext);
      end
      ns = $urandom_range(stall_max, stall_min);
      for (int s = 0; s < ns; s++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (act_valid !== 1'b1 || ext_ram !== exp_ext || act_idx !== 3'(i) ||
            ext_header !== exp_hdr || act_cnt !== exp_act) begin
          n_err++; $display("FAIL stall_hold idx=%0d vld=%0b ram=%0h exp=%0h act_cnt=%0d exp=%0d",
                            i, act_valid, ext_ram, exp_ext, act_cnt, exp_act);
        end
      end
      act_ready = 1'b1;
      @(posedge clk); #1;
      act_ready = 1'b0;
      exp_act++;
      n_cmp++;
      if (act_cnt !== exp_act) begin
        n_err++; $display("FAIL act_cnt act=%0d exp=%0d", act_cnt, exp_act);
      end
      if (i == int'(cnt) - 1) begin
        exp_pkt++;
        n_cmp++;
        if (pkt_done !== 1'b1 || pkt_cnt !== exp_pkt || act_valid !== 1'b0 || hdr_ready !== 1'b1) begin
          n_err++; $display("FAIL pkt_end done=%0b pkt=%0d exp=%0d vld=%0b rdy=%0b",
                            pkt_done, pkt_cnt, exp_pkt, act_valid, hdr_ready);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({hdr_ready, ram_rd_en, act_valid, act_last, pkt_done} !== 5'b10000 ||
        ram_addr !== 8'h0 || act_idx !== 3'd0 || pkt_cnt !== 32'd0 || act_cnt !== 32'd0 ||
        ext_ram !== 80'h0 || ext_offset !== 12'h0 || ext_header !== 2048'h0) begin
      n_err++; $display("FAIL reset_vals flags=%b exp=10000 pkt=%0d act=%0d ram=%0h",
                        {hdr_ready, ram_rd_en, act_valid, act_last, pkt_done}, pkt_cnt, act_cnt, ext_ram);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_pkt = '0; exp_act = '0; exp_ext = '0;
  endtask

  task automatic test_single_rule();
    run_pkt(8'h10, 3'd1, 0, 0);
    n_cmp++;
    if (pkt_cnt !== 32'd1 || act_cnt !== 32'd1) begin
      n_err++; $display("FAIL single_counts pkt=%0d act=%0d exp=1/1", pkt_cnt, act_cnt);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (pkt_done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse act=%0b exp=0", pkt_done);
    end
  endtask

  task automatic test_backpressure();
    run_pkt(8'h10, 3'd3, 5, 5);
    n_cmp++;
    if (act_cnt !== 32'd4) begin
      n_err++; $display("FAIL bp_act_cnt act=%0d exp=4", act_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    run_pkt(8'hFE, 3'd3, 0, 2);
  endtask

  task automatic test_zero_rules();
    run_pkt(8'h33, 3'd0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (pkt_done !== 1'b0 || ram_rd_en !== 1'b0 || hdr_ready !== 1'b1) begin
      n_err++; $display("FAIL zero_after done=%0b rd=%0b rdy=%0b exp=0/0/1", pkt_done, ram_rd_en, hdr_ready);
    end
  endtask

  task automatic test_flush_out();
    exp_hdr = rand_hdr();
    hdr_valid = 1'b1; hdr_data = exp_hdr; hdr_offset = 12'h5A5;
    rule_base = 8'h40; rule_cnt = 3'd4;
    @(posedge clk); #1; hdr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    act_ready = 1'b1;
    @(posedge clk); #1;
    act_ready = 1'b0; exp_act++;
    n_cmp++;
    if (ram_rd_en !== 1'b1 || ram_addr !== 8'h41) begin
      n_err++; $display("FAIL flush_rd1 rd=%0b addr=%0h exp=1/41", ram_rd_en, ram_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (act_valid !== 1'b1 || act_idx !== 3'd1 || ext_ram !== mem[8'h41]) begin
      n_err++; $display("FAIL flush_pre vld=%0b idx=%0d ram=%0h exp=%0h", act_valid, act_idx, ext_ram, mem[8'h41]);
    end
    act_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    act_ready = 1'b0; flush = 1'b0;
    n_cmp++;
    if (act_valid !== 1'b0 || hdr_ready !== 1'b1 || pkt_done !== 1'b0 ||
        act_cnt !== exp_act || pkt_cnt !== exp_pkt) begin
      n_err++; $display("FAIL flush_out vld=%0b rdy=%0b done=%0b act=%0d/%0d pkt=%0d/%0d",
                        act_valid, hdr_ready, pkt_done, act_cnt, exp_act, pkt_cnt, exp_pkt);
    end
    run_pkt(8'h50, 3'd2, 0, 1);
  endtask

  task automatic test_flush_load();
    // flush while idle must not block a header arriving in the same cycle
    exp_hdr = rand_hdr();
    hdr_valid = 1'b1; flush = 1'b1; hdr_data = exp_hdr; hdr_offset = 12'h123;
    rule_base = 8'h80; rule_cnt = 3'd2;
    @(posedge clk); #1; hdr_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (ram_rd_en !== 1'b1 || ram_addr !== 8'h80) begin
      n_err++; $display("FAIL idle_flush_accept rd=%0b addr=%0h exp=1/80", ram_rd_en, ram_addr);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (act_valid !== 1'b0 || hdr_ready !== 1'b1 || pkt_done !== 1'b0 || ext_ram !== exp_ext ||
        ext_header !== exp_hdr || ext_offset !== 12'h123) begin
      n_err++; $display("FAIL flush_load vld=%0b rdy=%0b done=%0b ram=%0h exp=%0h",
                        act_valid, hdr_ready, pkt_done, ext_ram, exp_ext);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (pkt_cnt !== exp_pkt || act_cnt !== exp_act || ext_ram !== exp_ext) begin
      n_err++; $display("FAIL flush_load_cnt pkt=%0d/%0d act=%0d/%0d", pkt_cnt, exp_pkt, act_cnt, exp_act);
    end
  endtask

  task automatic test_reset_mid_load();
    hdr_valid = 1'b1; hdr_data = rand_hdr(); hdr_offset = 12'hABC;
    rule_base = 8'h20; rule_cnt = 3'd2;
    @(posedge clk); #1; hdr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hdr_ready, ram_rd_en, act_valid, act_last, pkt_done} !== 5'b10000 ||
        pkt_cnt !== 32'd0 || act_cnt !== 32'd0 || ext_ram !== 80'h0 ||
        ext_header !== 2048'h0 || ext_offset !== 12'h0 || act_idx !== 3'd0) begin
      n_err++; $display("FAIL reset_mid flags=%b exp=10000 pkt=%0d act=%0d off=%0h",
                        {hdr_ready, ram_rd_en, act_valid, act_last, pkt_done}, pkt_cnt, act_cnt, ext_offset);
    end
    exp_pkt = '0; exp_act = '0; exp_ext = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_pkt(8'h21, 3'd1, 0, 0);
  endtask

  task automatic test_back_to_back();
    time t0;
    logic [2:0] c;
    for (int p = 0; p < 6; p++) begin
      c = (p == 2) ? 3'd0 : 3'($urandom_range(7, 0));
      t0 = $time;
      run_pkt(8'($urandom), c, 0, 0);
      n_cmp++;
      if (($time - t0) !== time'((3 * int'(c) + 1) * 10)) begin
        n_err++; $display("FAIL throughput cnt=%0d act=%0t exp=%0d", c, $time - t0, (3 * int'(c) + 1) * 10);
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      run_pkt(8'($urandom), 3'($urandom_range(7, 0)), 0, 3);
      for (int g = $urandom_range(2, 0); g > 0; g--) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    exp_pkt = '0; exp_act = '0; exp_ext = '0;
    flush = 1'b0; hdr_valid = 1'b0; act_ready = 1'b0;
    hdr_data = '0; hdr_offset = '0; rule_base = '0; rule_cnt = '0;
    ram_rdata = '0;
    for (int k = 0; k < 256; k++) mem[k] = {16'($urandom), $urandom, $urandom};
    test_reset();
    test_single_rule();
    test_backpressure();
    test_addr_wrap();
    test_zero_rules();
    test_flush_out();
    test_flush_load();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
